// File: rtl/l1_mmu_arbiter.sv
// Grant-locked arbiter sharing the single l1mmu line port between the iCache and the dCache.
// One transaction in flight; a saturating counter keeps iCache fills from starving the dCache.
module l1_mmu_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              ic_req_read,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_done,
  output logic [LINE_W-1:0] ic_read_data,
  input  logic              dc_req_read,
  input  logic              dc_req_write,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_done,
  output logic [LINE_W-1:0] dc_read_data,
  output logic              mmu_req_read,
  output logic              mmu_req_write,
  output logic [ADDR_W-1:0] mmu_req_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_I  = 2'd1,
    ST_BUSY_D  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic                req_read_q, req_read_d;
  logic                req_write_q, req_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                dc_pend_s;
  logic                grant_d_s;
  logic                grant_i_s;

  // Arbitration and transaction sequencing; requests are only looked at in IDLE.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    req_read_d  = req_read_q;
    req_write_d = req_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dc_pend_s   = dc_req_read | dc_req_write;
    grant_d_s   = dc_pend_s & (~ic_req_read | (starve_q >= STARVE_MAX));
    grant_i_s   = ~grant_d_s & ic_req_read;
    case (state_q)
      ST_IDLE: begin
        if (grant_d_s) begin
          state_d     = ST_BUSY_D;
          addr_d      = dc_req_addr;
          wdata_d     = dc_write_data;
          req_write_d = dc_req_write;
          req_read_d  = ~dc_req_write;
          starve_d    = 4'd0;
        end else if (grant_i_s) begin
          state_d     = ST_BUSY_I;
          addr_d      = ic_req_addr;
          req_read_d  = 1'b1;
          req_write_d = 1'b0;
          // Count only grants that made a waiting dCache stand aside; saturate, never wrap.
          if (dc_pend_s) begin
            starve_d = (starve_q < STARVE_MAX) ? (starve_q + 4'd1) : starve_q;
          end else begin
            starve_d = 4'd0;
          end
        end else begin
          starve_d = 4'd0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mmu_done) begin
          state_d     = ST_RELEASE;
          req_read_d  = 1'b0;
          req_write_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        req_read_d  = 1'b0;
        req_write_d = 1'b0;
      end
    endcase
  end

  // State and request registers; async reset drops any in-flight transaction.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      starve_q    <= 4'd0;
      req_read_q  <= 1'b0;
      req_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      req_read_q  <= req_read_d;
      req_write_q <= req_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign mmu_req_read   = req_read_q;
  assign mmu_req_write  = req_write_q;
  assign mmu_req_addr   = addr_q;
  assign mmu_write_data = wdata_q;

  // Completion is forwarded in the mmu_done cycle, and only to the current owner.
  assign ic_done      = (state_q == ST_BUSY_I) & mmu_done;
  assign dc_done      = (state_q == ST_BUSY_D) & mmu_done;
  assign ic_read_data = mmu_read_data;
  assign dc_read_data = mmu_read_data;

endmodule

// File: tb/tb_l1_mmu_arbiter.sv
// Self-checking bench for l1_mmu_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_l1_mmu_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int LIMIT  = 4;

  logic              sys_clk;
  logic              rst_n;
  logic              ic_req_read;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_done;
  logic [LINE_W-1:0] ic_read_data;
  logic              dc_req_read;
  logic              dc_req_write;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [LINE_W-1:0] dc_write_data;
  logic              dc_done;
  logic [LINE_W-1:0] dc_read_data;
  logic              mmu_req_read;
  logic              mmu_req_write;
  logic [ADDR_W-1:0] mmu_req_addr;
  logic [LINE_W-1:0] mmu_write_data;
  logic              mmu_done;
  logic [LINE_W-1:0] mmu_read_data;

  int errors = 0;
  int checks = 0;

  // Reference model: owner 0=none 1=iCache 2=dCache; gap = bubble cycles left before re-arbitration.
  int                m_owner;
  int                m_gap;
  int                m_starve;
  logic              m_rd;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;

  l1_mmu_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(LIMIT)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .ic_req_read(ic_req_read), .ic_req_addr(ic_req_addr),
    .ic_done(ic_done), .ic_read_data(ic_read_data),
    .dc_req_read(dc_req_read), .dc_req_write(dc_req_write),
    .dc_req_addr(dc_req_addr), .dc_write_data(dc_write_data),
    .dc_done(dc_done), .dc_read_data(dc_read_data),
    .mmu_req_read(mmu_req_read), .mmu_req_write(mmu_req_write),
    .mmu_req_addr(mmu_req_addr), .mmu_write_data(mmu_write_data),
    .mmu_done(mmu_done), .mmu_read_data(mmu_read_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_gap = 0; m_starve = 0;
    m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
  endtask

  // One clock edge of the arbitration rules, applied to the inputs present at that edge.
  task automatic model_edge();
    logic dcp;
    dcp = dc_req_read | dc_req_write;
    if (m_owner != 0) begin
      if (mmu_done) begin
        m_owner = 0; m_gap = 1; m_rd = 1'b0; m_wr = 1'b0;
      end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else if (dcp && (!ic_req_read || m_starve >= LIMIT)) begin
      m_owner = 2; m_starve = 0;
      m_addr = dc_req_addr; m_wdata = dc_write_data;
      m_wr = dc_req_write; m_rd = !dc_req_write;
    end else if (ic_req_read) begin
      m_owner = 1; m_addr = ic_req_addr; m_rd = 1'b1; m_wr = 1'b0;
      m_starve = dcp ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
    end else begin
      m_starve = 0;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ic_req_read = 1'b0; ic_req_addr = '0;
    dc_req_read = 1'b0; dc_req_write = 1'b0; dc_req_addr = '0; dc_write_data = '0;
    mmu_done = 1'b0; mmu_read_data = '0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a grant, answers it after lat cycles, reports what was seen.
  task automatic run_txn(input int lat, output logic [ADDR_W-1:0] g_addr, output logic g_wr,
                         output logic g_ic_done, output logic g_dc_done, output logic ok);
    ok = 1'b0; g_addr = '0; g_wr = 1'b0; g_ic_done = 1'b0; g_dc_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (mmu_req_read || mmu_req_write) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) begin
      g_addr = mmu_req_addr;
      g_wr   = mmu_req_write;
      repeat (lat) tick();
      mmu_done = 1'b1; mmu_read_data = rand_line();
      #1;
      g_ic_done = ic_done; g_dc_done = dc_done;
      tick();
      mmu_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    ic_req_read = 1'b1; ic_req_addr = 32'h0000_2000;
    dc_req_read = 1'b1; dc_req_write = 1'b0; dc_req_addr = 32'h0000_3000; dc_write_data = '0;
    mmu_done = 1'b0; mmu_read_data = '0;
    repeat (3) @(negedge sys_clk);
    checks++; if ({mmu_req_read, mmu_req_write, ic_done, dc_done} !== 4'b0000) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {mmu_req_read, mmu_req_write, ic_done, dc_done}); end
    checks++; if (mmu_req_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mmu_req_addr); end
    checks++; if (mmu_write_data !== '0) begin errors++; $display("FAIL reset_wdata: got nonzero expected 0"); end
    rst_n = 1'b1;
    tick();
    checks++; if ({mmu_req_read, mmu_req_write} !== 2'b10) begin errors++;
      $display("FAIL reset_first_grant: got rd/wr %b expected 10", {mmu_req_read, mmu_req_write}); end
    checks++; if (mmu_req_addr !== 32'h0000_2000) begin errors++;
      $display("FAIL reset_grant_addr: got %h expected 00002000", mmu_req_addr); end
    mmu_done = 1'b1; #1;
    checks++; if ({ic_done, dc_done} !== 2'b10) begin errors++;
      $display("FAIL reset_ic_done: got ic/dc %b expected 10", {ic_done, dc_done}); end
    tick(); mmu_done = 1'b0;
  endtask

  task automatic test_dc_write();
    logic [LINE_W-1:0] pat;
    do_reset();
    pat = {8{32'hA5C3_0F96}};
    dc_req_write = 1'b1; dc_req_addr = 32'h1000_0040; dc_write_data = pat;
    tick();
    checks++; if ({mmu_req_read, mmu_req_write} !== 2'b01) begin errors++;
      $display("FAIL dcw_op: got rd/wr %b expected 01", {mmu_req_read, mmu_req_write}); end
    checks++; if (mmu_req_addr !== 32'h1000_0040 || mmu_write_data !== pat) begin errors++;
      $display("FAIL dcw_addr_data: got addr %h expected 10000040", mmu_req_addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({mmu_req_write, ic_done, dc_done} !== 3'b100) begin errors++;
        $display("FAIL dcw_hold: cycle %0d got wr/icd/dcd %b expected 100", i, {mmu_req_write, ic_done, dc_done}); end
    end
    mmu_done = 1'b1; mmu_read_data = rand_line(); #1;
    checks++; if ({ic_done, dc_done} !== 2'b01) begin errors++;
      $display("FAIL dcw_done: got ic/dc %b expected 01", {ic_done, dc_done}); end
    tick(); mmu_done = 1'b0; dc_req_write = 1'b0; #1;
    checks++; if ({mmu_req_read, mmu_req_write, ic_done, dc_done} !== 4'b0000) begin errors++;
      $display("FAIL dcw_release: got %b expected 0000", {mmu_req_read, mmu_req_write, ic_done, dc_done}); end
    tick();
    checks++; if ({mmu_req_read, mmu_req_write} !== 2'b00) begin errors++;
      $display("FAIL dcw_idle: got %b expected 00", {mmu_req_read, mmu_req_write}); end
  endtask

  task automatic test_starvation();
    logic [ADDR_W-1:0] ga; logic gw, gi, gd, ok;
    do_reset();
    ic_req_read = 1'b1; ic_req_addr = 32'h0000_0100;
    dc_req_read = 1'b1; dc_req_addr = 32'h0000_0200;
    for (int k = 0; k < 10; k++) begin
      run_txn($urandom_range(0, 3), ga, gw, gi, gd, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL starve_timeout: grant %0d never came", k); end
      checks++; if (ga !== ((k % 5 == 4) ? 32'h0000_0200 : 32'h0000_0100)) begin errors++;
        $display("FAIL starve_order: grant %0d got addr %h expected %h", k, ga,
                 ((k % 5 == 4) ? 32'h0000_0200 : 32'h0000_0100)); end
    end
    ic_req_read = 1'b0; dc_req_read = 1'b0;
  endtask

  task automatic test_ic_drop();
    logic [ADDR_W-1:0] ga; logic gw, gi, gd, ok;
    do_reset();
    ic_req_read = 1'b1; ic_req_addr = 32'h0000_0A00;
    dc_req_read = 1'b1; dc_req_addr = 32'h0000_0B00;
    run_txn(2, ga, gw, gi, gd, ok);
    ic_req_read = 1'b0;
    checks++; if (ok !== 1'b1 || ga !== 32'h0000_0A00 || gi !== 1'b1) begin errors++;
      $display("FAIL drop_first_i: got addr %h icd %b expected 00000a00 1", ga, gi); end
    run_txn(1, ga, gw, gi, gd, ok);
    checks++; if (ok !== 1'b1 || ga !== 32'h0000_0B00 || gd !== 1'b1) begin errors++;
      $display("FAIL drop_then_d: got addr %h dcd %b expected 00000b00 1", ga, gd); end
    // With the counter cleared by the D grant, four I grants must precede the next D.
    ic_req_read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_txn(0, ga, gw, gi, gd, ok);
      checks++; if (ok !== 1'b1 || ga !== ((k == 4) ? 32'h0000_0B00 : 32'h0000_0A00)) begin errors++;
        $display("FAIL drop_counter_cleared: grant %0d got addr %h", k, ga); end
    end
    ic_req_read = 1'b0; dc_req_read = 1'b0;
  endtask

  task automatic test_spurious_and_reset();
    do_reset();
    tick();
    mmu_done = 1'b1; #1;
    checks++; if ({ic_done, dc_done} !== 2'b00) begin errors++;
      $display("FAIL spurious_done: got ic/dc %b expected 00", {ic_done, dc_done}); end
    tick(); mmu_done = 1'b0;
    checks++; if ({mmu_req_read, mmu_req_write} !== 2'b00) begin errors++;
      $display("FAIL spurious_state: got %b expected 00", {mmu_req_read, mmu_req_write}); end
    dc_req_read = 1'b1; dc_req_addr = 32'h0000_0C40;
    tick();
    checks++; if ({mmu_req_read, mmu_req_write} !== 2'b10 || mmu_req_addr !== 32'h0000_0C40) begin errors++;
      $display("FAIL busyd_grant: got rd/wr %b addr %h", {mmu_req_read, mmu_req_write}, mmu_req_addr); end
    #2; rst_n = 1'b0; mmu_done = 1'b1; #1;
    checks++; if ({mmu_req_read, mmu_req_write, ic_done, dc_done} !== 4'b0000 || mmu_req_addr !== 32'h0) begin errors++;
      $display("FAIL async_reset: got %b addr %h expected 0000 0",
               {mmu_req_read, mmu_req_write, ic_done, dc_done}, mmu_req_addr); end
    @(negedge sys_clk);
    mmu_done = 1'b0; dc_req_read = 1'b0; model_reset(); rst_n = 1'b1;
    tick();
    checks++; if ({mmu_req_read, mmu_req_write, dc_done} !== 3'b000) begin errors++;
      $display("FAIL post_reset_idle: got %b expected 000", {mmu_req_read, mmu_req_write, dc_done}); end
  endtask

  task automatic test_precedence_and_hold();
    logic [ADDR_W-1:0] ga; logic gw, gi, gd, ok;
    do_reset();
    dc_req_read = 1'b1; dc_req_write = 1'b1; dc_req_addr = 32'h0000_0D00; dc_write_data = rand_line();
    tick();
    checks++; if ({mmu_req_read, mmu_req_write} !== 2'b01) begin errors++;
      $display("FAIL rw_precedence: got rd/wr %b expected 01", {mmu_req_read, mmu_req_write}); end
    run_txn(1, ga, gw, gi, gd, ok);
    dc_req_read = 1'b0; dc_req_write = 1'b0;
    repeat (2) tick();
    ic_req_read = 1'b1; ic_req_addr = 32'h0000_0E00;
    tick();
    ic_req_addr = 32'h0000_0F80;
    repeat (3) tick();
    checks++; if (mmu_req_addr !== 32'h0000_0E00 || mmu_req_read !== 1'b1) begin errors++;
      $display("FAIL addr_hold: got addr %h rd %b expected 00000e00 1", mmu_req_addr, mmu_req_read); end
    run_txn(0, ga, gw, gi, gd, ok);
    ic_req_read = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic exp_ic, exp_dc;
    int lat;
    do_reset();
    lat = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!ic_req_read) begin
        if ($urandom_range(0, 2) == 0) begin ic_req_read = 1'b1; ic_req_addr = $urandom; end
      end else if ($urandom_range(0, 4) == 0) ic_req_addr = $urandom;
      if (!(dc_req_read || dc_req_write)) begin
        if ($urandom_range(0, 2) == 0) begin
          op = 2'($urandom_range(1, 3));
          dc_req_read = op[0]; dc_req_write = op[1];
          dc_req_addr = $urandom; dc_write_data = rand_line();
        end
      end else if ($urandom_range(0, 4) == 0) dc_req_addr = $urandom;
      if (mmu_req_read || mmu_req_write) begin
        if (lat == 0) mmu_done = 1'b1;
        else begin mmu_done = 1'b0; lat = lat - 1; end
      end else begin
        lat = $urandom_range(0, 4);
        mmu_done = ($urandom_range(0, 7) == 0);
      end
      mmu_read_data = rand_line();
      #1;
      exp_ic = (m_owner == 1) && mmu_done;
      exp_dc = (m_owner == 2) && mmu_done;
      checks++; if ({ic_done, dc_done} !== {exp_ic, exp_dc}) begin errors++;
        $display("FAIL rand_done: cycle %0d got ic/dc %b expected %b", cyc, {ic_done, dc_done}, {exp_ic, exp_dc}); end
      if (exp_ic || exp_dc) begin
        checks++; if (ic_read_data !== mmu_read_data || dc_read_data !== mmu_read_data) begin errors++;
          $display("FAIL rand_rdata: cycle %0d read data not forwarded", cyc); end
      end
      tick();
      mmu_done = 1'b0;
      if (exp_ic) ic_req_read = 1'b0;
      if (exp_dc) begin dc_req_read = 1'b0; dc_req_write = 1'b0; end
      checks++; if ({mmu_req_read, mmu_req_write} !== {m_rd, m_wr} || mmu_req_addr !== m_addr) begin errors++;
        $display("FAIL rand_req: cycle %0d got rd/wr %b addr %h expected %b %h", cyc,
                 {mmu_req_read, mmu_req_write}, mmu_req_addr, {m_rd, m_wr}, m_addr); end
      checks++; if (mmu_write_data !== m_wdata) begin errors++;
        $display("FAIL rand_wdata: cycle %0d got %h expected %h", cyc, mmu_write_data[31:0], m_wdata[31:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_dc_write();
    test_starvation();
    test_ic_drop();
    test_spurious_and_reset();
    test_precedence_and_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
